// File: rtl/clock_switch_ctrl_if.sv
// Bundle between the clock-switch sequencer and its requester / clock mux.
// Handshake: a request transfers on a clk edge where req_valid & req_ready; req_sel is held with req_valid.
interface clock_switch_ctrl_if #(
  parameter int N = 2
) ();
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic          req_valid;
  logic [SW-1:0] req_sel;
  logic          req_ready;
  logic [N-1:0]  sel_ack;
  logic [N-1:0]  select;
  logic [SW-1:0] cur_sel;
  logic          done;
  logic          err;
  logic          busy;
  logic [2:0]    fsm_state;

  modport master (
    output req_valid, req_sel, sel_ack,
    input  req_ready, select, cur_sel, done, err, busy, fsm_state
  );

  modport slave (
    input  req_valid, req_sel, sel_ack,
    output req_ready, select, cur_sel, done, err, busy, fsm_state
  );
endinterface

// File: rtl/clock_switch_ctrl.sv
// Sequencer driving the select vector of a glitch-free N-input clock mux.
// Optional wait-state timeout with fallback to the previous source: define CLK_SW_TIMEOUT_EN.
module clock_switch_ctrl #(
  parameter int N           = 2,
  parameter int STAGES      = 2,
  parameter int DEFAULT_SEL = 0,
  parameter int TIMEOUT     = 64
) (
  input logic           clk,
  input logic           rst,
  clock_switch_ctrl_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || STAGES < 2 || DEFAULT_SEL >= N || TIMEOUT < 1) begin : g_param_check
    $error("clock_switch_ctrl: illegal parameter set");
  end

`ifdef CLK_SW_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OFF = 3'd1,
    WAIT_ON  = 3'd2,
    DROP     = 3'd3,
    RESTORE  = 3'd4
  } state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OFF = 3'd1,
    WAIT_ON  = 3'd2
  } state_t;
`endif

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Acknowledge synchronizer; sel_ack is asynchronous to clk.
  logic [N-1:0] sync_q [STAGES];
  logic [N-1:0] ack_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.sel_ack;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ack_s = sync_q[STAGES-1];

  state_t        state_q, state_d;
  logic [N-1:0]  select_q, select_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic [SW-1:0] tgt_q, tgt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef CLK_SW_TIMEOUT_EN
  logic [SW-1:0] prv_q, prv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      select_q  <= onehot(SW'(DEFAULT_SEL));
      cur_sel_q <= SW'(DEFAULT_SEL);
      tgt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CLK_SW_TIMEOUT_EN
      prv_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      cur_sel_q <= cur_sel_d;
      tgt_q     <= tgt_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CLK_SW_TIMEOUT_EN
      prv_q     <= prv_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    select_d  = select_q;
    cur_sel_d = cur_sel_q;
    tgt_d     = tgt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef CLK_SW_TIMEOUT_EN
    prv_d     = prv_q;
    cnt_d     = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (int'(bus.req_sel) >= N) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (bus.req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d    = bus.req_sel;
            select_d = '0;
            state_d  = WAIT_OFF;
`ifdef CLK_SW_TIMEOUT_EN
            prv_d    = cur_sel_q;
`endif
          end
        end
      end
      WAIT_OFF: begin
        // The old source must be fully released before the new one is enabled.
        if (ack_s == '0) begin
          select_d = onehot(tgt_q);
          state_d  = WAIT_ON;
`ifdef CLK_SW_TIMEOUT_EN
        end else if (expired) begin
          state_d  = DROP;
        end else begin
          cnt_d    = cnt_q + CW'(1);
`endif
        end
      end
      WAIT_ON: begin
        if (ack_s == onehot(tgt_q)) begin
          cur_sel_d = tgt_q;
          done_d    = 1'b1;
          state_d   = IDLE;
`ifdef CLK_SW_TIMEOUT_EN
        end else if (expired) begin
          select_d  = '0;
          state_d   = DROP;
        end else begin
          cnt_d     = cnt_q + CW'(1);
`endif
        end
      end
`ifdef CLK_SW_TIMEOUT_EN
      // One all-zero cycle before falling back to the previous source.
      DROP: begin
        select_d = onehot(prv_q);
        state_d  = RESTORE;
      end
      RESTORE: begin
        if (ack_s == onehot(prv_q)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        select_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.select    = select_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Randomized bench for clock_switch_ctrl: a delayed mux model feeds sel_ack back,
// a request-level model predicts each outcome, and a monitor checks every done pulse.
module tb_clock_switch_ctrl;
  localparam int N           = 5;
  localparam int STAGES      = 2;
  localparam int DEFAULT_SEL = 0;
  localparam int TIMEOUT     = 16;
  localparam int SW          = $clog2(N);
  localparam int MUX_DLY     = 3;
  localparam int MIN_LAT     = 2 * STAGES + 2;

  typedef struct packed {
    logic          err;
    logic [SW-1:0] cur;
    logic [N-1:0]  sel_vec;
    logic          imm;
    logic [15:0]   acc;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int model_cur = DEFAULT_SEL;
  int b2b_count = 0;
  logic [N-1:0] dead_mask = '0;
  logic [N-1:0] mux_pipe [MUX_DLY];
  logic [N-1:0] prev_sel;
  logic [EW-1:0] exp_q [$];

  clock_switch_ctrl_if #(.N(N)) bus ();

  clock_switch_ctrl #(
    .N(N), .STAGES(STAGES), .DEFAULT_SEL(DEFAULT_SEL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mux model: each enabled source acknowledges MUX_DLY cycles after select; dead sources never do.
  always @(posedge clk) begin
    mux_pipe[0] <= bus.select & ~dead_mask;
    for (int i = 1; i < MUX_DLY; i++) mux_pipe[i] <= mux_pipe[i-1];
  end
  assign bus.sel_ack = mux_pipe[MUX_DLY-1];

  assert property (@(posedge clk) disable iff (rst) $onehot0(bus.select));

  function automatic void check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic void check_ok(input string name, input bit ok, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Request-level reference: outcome depends only on the index, the engaged source and dead sources.
  function automatic exp_t model_req(input int sel, input int acc);
    exp_t e;
    e.acc = 16'(acc);
    e.imm = 1'b1;
    e.err = 1'b0;
    if (sel >= N) begin
      e.err = 1'b1;
    end else if (sel == model_cur) begin
      e.err = 1'b0;
    end else if (dead_mask[sel]) begin
      e.err = 1'b1;
      e.imm = 1'b0;
    end else begin
      e.imm = 1'b0;
      model_cur = sel;
    end
    e.cur     = SW'(model_cur);
    e.sel_vec = N'(1) << model_cur;
    return e;
  endfunction

  // Driver tasks
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    model_cur = DEFAULT_SEL;
  endtask

  task automatic send_req(input int sel);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.req_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check_eq("req_ready_wait", 64'(bus.req_ready), 64'd1);
      return;
    end
    if (bus.done) b2b_count++;
    bus.req_valid = 1'b1;
    bus.req_sel   = SW'(sel);
    e = model_req(sel, cyc + 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_q.size() != 0 || !bus.req_ready) && guard < 400);
    if (guard >= 400) check_eq("idle_wait", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor
  initial begin : monitor
    exp_t e;
    int lat;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.select !== prev_sel)
          check_ok("select_transition", $onehot0(bus.select) && (prev_sel == '0 || bus.select == '0),
                   64'({prev_sel, bus.select}), 64'(0));
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_done", 64'(bus.done), 64'd0);
          end else begin
            e = exp_t'(exp_q.pop_front());
            check_eq("done_result", 64'({bus.err, bus.cur_sel, bus.select, bus.req_ready}),
                     64'({e.err, e.cur, e.sel_vec, 1'b1}));
            lat = cyc - int'(e.acc);
            if (e.imm) check_eq("imm_latency", 64'(lat), 64'd0);
            else check_ok("switch_latency", lat >= MIN_LAT, 64'(lat), 64'(MIN_LAT));
          end
        end
      end
      prev_sel = bus.select;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int tgt;
    int hold;
    int guard;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;

    do_reset(6);
    @(negedge clk);
    check_eq("reset_select", 64'(bus.select), 64'(N'(1) << DEFAULT_SEL));
    check_eq("reset_cur_sel", 64'(bus.cur_sel), 64'(DEFAULT_SEL));
    check_eq("reset_ready", 64'(bus.req_ready), 64'd1);
    check_eq("reset_done", 64'(bus.done), 64'd0);
    check_eq("reset_busy", 64'(bus.busy), 64'd0);

    // Directed: normal switch, same source, out-of-range indices
    send_req(2);
    wait_idle();
    send_req(2);
    send_req(5);
    send_req(7);
    wait_idle();

    // Randomized, mostly back-to-back
    for (int i = 0; i < 40; i++) begin
      send_req(int'($urandom_range(0, (1 << SW) - 1)));
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();

`ifdef CLK_SW_TIMEOUT_EN
    // Dead target: fall back to the previous source after TIMEOUT cycles in WAIT_ON
    if (model_cur == 3) begin
      send_req(1);
      wait_idle();
    end
    dead_mask = N'(1) << 3;
    send_req(3);
    guard = 0;
    while (bus.select != (N'(1) << 3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    hold = 0;
    while (bus.select == (N'(1) << 3) && hold < 200) begin
      @(negedge clk);
      hold++;
    end
    check_eq("dead_target_hold", 64'(hold), 64'(TIMEOUT));
    check_eq("dead_target_drop", 64'(bus.select), 64'd0);
    wait_idle();
    dead_mask = '0;
`endif

    // Reset in the middle of a switch (WAIT_OFF)
    tgt = (model_cur + 1 + int'($urandom_range(0, N - 2))) % N;
    send_req(tgt);
    @(negedge clk);
    check_eq("mid_switch_state", 64'({bus.busy, bus.select}), 64'({1'b1, N'(0)}));
    rst = 1'b1;
    do_reset(1);
    @(negedge clk);
    check_eq("mid_reset_select", 64'(bus.select), 64'(N'(1) << DEFAULT_SEL));
    check_eq("mid_reset_cur_sel", 64'(bus.cur_sel), 64'(DEFAULT_SEL));
    check_eq("mid_reset_idle", 64'({bus.req_ready, bus.busy, bus.done}), 64'({1'b1, 1'b0, 1'b0}));
    repeat (15) @(negedge clk);

    for (int i = 0; i < 12; i++) send_req(int'($urandom_range(0, (1 << SW) - 1)));
    wait_idle();

    check_ok("back_to_back_seen", b2b_count > 0, 64'(b2b_count), 64'd1);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_switch_ctrl.md
# clock_switch_ctrl

Sequencer that owns the `select` vector of a glitch-free N-input clock multiplexer. It runs on an always-on reference clock and accepts source-change requests over a valid/ready handshake. Each switch is executed as deselect → wait for release → select → wait for engage, using synchronized per-source acknowledge feedback from the mux. It reports completion or failure per request.

## Interface
- `N`, 2: number of clock sources; must be ≥ 2.
- `STAGES`, 2: synchronizer depth on `sel_ack`; must be ≥ 2.
- `DEFAULT_SEL`, 0: source selected out of reset; must be < N.
- `TIMEOUT`, 64: maximum cycles spent in any wait state; must be ≥ 1. Used only with `CLK_SW_TIMEOUT_EN`.
- `SW`: $clog2(N) (derived).

Ports:
- `clk`  in  1  always-on reference clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  switch request.
- `req_sel`  in  SW  requested source index.
- `req_ready`  out  1  high only in IDLE.
- `sel_ack`  in  N  per-source "gated clock enabled" status from the mux; asynchronous.
- `select`  out  N  one-hot or all-zero select driven to the mux.
- `cur_sel`  out  SW  index of the currently engaged source.
- `done`  out  1  one-cycle pulse when a request completes.
- `err`  out  1  qualified by `done`: 1 means the request failed.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- `sel_ack` passes through an STAGES-flop synchronizer per bit. Synchronizer flops reset to 0. All decisions use the synchronized value `ack_s`.
- States: IDLE, WAIT_OFF, WAIT_ON, RESTORE.
- IDLE, on acceptance (`req_valid & req_ready`):
  - `req_sel` ≥ N → stay in IDLE; `done=1`, `err=1` next cycle; `select` unchanged.
  - `req_sel == cur_sel` → stay in IDLE; `done=1`, `err=0` next cycle; `select` unchanged.
  - Otherwise → latch target `tgt` and previous `prv=cur_sel`; `select<=0`; go to WAIT_OFF.
- WAIT_OFF: when `ack_s == 0` → `select <= 1<<tgt`; go to WAIT_ON.
- WAIT_ON: when `ack_s == 1<<tgt` → `cur_sel<=tgt`; `done=1`, `err=0`; go to IDLE.
- RESTORE (timeout path only):
  - Entry: `select` has already been set to `1<<prv`.
  - When `ack_s == 1<<prv` → `done=1`, `err=1`; go to IDLE. `cur_sel` stays `prv`.
  - RESTORE has no timeout; it waits indefinitely.
- `select` never has more than one bit set. Every transition between two different one-hot values passes through all-zero for at least one cycle.
- `req_valid` is ignored while `req_ready=0`; no queueing.
- Reset at any cycle, including mid-switch:
  - State → IDLE.
  - `select = 1<<DEFAULT_SEL`, `cur_sel = DEFAULT_SEL`.
  - `done=0`, `err=0`, `busy=0`, `req_ready=1` from the first cycle after reset is sampled.

## Timing
- Acceptance edge E0: `select` becomes 0 at E0.
- Earliest WAIT_OFF exit is the edge after `ack_s` reads 0. `ack_s` lags `sel_ack` by STAGES cycles.
- Minimum switch latency is 2·STAGES+2 cycles from acceptance to `done`, assuming the mux responds instantly.
- `done` and `err` are registered, valid for exactly one cycle, and coincide with the return to IDLE.
- `req_ready` is high in that same cycle, so back-to-back requests are accepted.
- `cur_sel` updates in the same cycle `done` rises.

## Configuration
- `CLK_SW_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to WAIT_OFF or WAIT_ON.
  - Timeout fires if the exit condition is not met by the TIMEOUT-th cycle in the state.
  - On timeout: `select<=0` for one cycle, then `select<=1<<prv`; go to RESTORE.
- `CLK_SW_TIMEOUT_EN` undefined:
  - No counter and no RESTORE state.
  - WAIT_OFF and WAIT_ON wait indefinitely.
  - `err` asserts only for out-of-range requests.

## Test plan
- Reset check (N=4, DEFAULT_SEL=0): release reset → `select=4'b0001`, `cur_sel=0`, `req_ready=1`, `done=0`.
- Normal switch: model mux acks mirror `select` after 3 source cycles; request `req_sel=2` → `select` goes 0001→0000→0100, `done`/`err=0`, `cur_sel=2`, latency ≥ 2·STAGES+2.
- Same source and out-of-range:
  - `req_sel=cur_sel` → `done=1`, `err=0` one cycle later; `select` untouched.
  - `req_sel=5` with N=4 → `done=1`, `err=1`.
- Dead target (timeout build, TIMEOUT=16): `sel_ack[3]` held 0; request 3 → timeout 16 cycles into WAIT_ON → `select` 1000→0000→prv one-hot → `done`, `err=1`; `cur_sel` unchanged.
- Reset mid-switch: assert `rst` during WAIT_OFF → next cycle `select=1<<DEFAULT_SEL`, IDLE, no `done`.
- Back-to-back and one-hot check: issue a new request in the `done` cycle → accepted; assertion `$onehot0(select)` holds on every cycle of the run.
